ext_unit_arbiter: RTL and testbench

- Shares one sign/zero-extension unit between two requesters (decode immediate path, ALU/branch-offset path) in the 16-bit accumulator datapath.
- Arbitrates round-robin, accepts one extension request at a time, and returns a registered 16-bit result with its requester ID over a valid/ready response channel.
- Supports field widths of 1, 4, 8 and 12 bits, each sign- or zero-extended to 16 bits.

---
 rtl/ext_pkg.sv | 22 ++
 rtl/ext_unit_arbiter_if.sv | 30 +++
 rtl/ext_core.sv | 27 ++
 rtl/ext_unit_arbiter.sv | 123 ++++++++++++
 tb/tb_ext_unit_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_pkg.sv
// rtl/ext_pkg.sv - shared constants and types for the extension-unit arbiter
// Purpose: result/field widths, requester count, width codes and FSM states
//          shared by the arbiter, its interface, the extension core and the bench.
// Ports:   none (package).
package ext_pkg;

  localparam int DATA_W  = 16;
  localparam int FIELD_W = 12;
  localparam int NREQ    = 2;

  localparam logic [1:0] W1  = 2'b00;
  localparam logic [1:0] W4  = 2'b01;
  localparam logic [1:0] W8  = 2'b10;
  localparam logic [1:0] W12 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ext_unit_arbiter_if.sv
// rtl/ext_unit_arbiter_if.sv - request/response bus of the extension-unit arbiter
// Purpose: bundles the per-requester request channel and the shared
//          valid/ready response channel.
// Signals: req_valid/req_ready/req_field/req_width/req_sign (requests),
//          rsp_valid/rsp_ready/rsp_id/rsp_data (response), busy (status).
// Modports: slave = arbiter side, master = requester/consumer side.
interface ext_unit_arbiter_if;

  logic [ext_pkg::NREQ-1:0]               req_valid;
  logic [ext_pkg::NREQ-1:0]               req_ready;
  logic [ext_pkg::NREQ*ext_pkg::FIELD_W-1:0] req_field;
  logic [ext_pkg::NREQ*2-1:0]             req_width;
  logic [ext_pkg::NREQ-1:0]               req_sign;
  logic                                   rsp_valid;
  logic                                   rsp_ready;
  logic                                   rsp_id;
  logic [ext_pkg::DATA_W-1:0]             rsp_data;
  logic                                   busy;

  modport slave (
    input  req_valid, req_field, req_width, req_sign, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_field, req_width, req_sign, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/ext_core.sv
// rtl/ext_core.sv - combinational sign/zero extension of a 1/4/8/12-bit field
// Purpose: extends the low bits of field selected by width to DATA_W bits.
// Ports:   field  in  FIELD_W  raw field, only the low bits of the chosen width matter
//          width  in  2        W1/W4/W8/W12 width code
//          sign   in  1        1 = sign-extend, 0 = zero-extend
//          result out DATA_W   extended value
module ext_core
  import ext_pkg::*;
(
  input  logic [FIELD_W-1:0] field,
  input  logic [1:0]         width,
  input  logic               sign,
  output logic [DATA_W-1:0]  result
);

  always_comb begin
    result = '0;
    case (width)
      W1:      result = {{(DATA_W-1){sign & field[0]}}, field[0]};
      W4:      result = {{(DATA_W-4){sign & field[3]}}, field[3:0]};
      W8:      result = {{(DATA_W-8){sign & field[7]}}, field[7:0]};
      W12:     result = {{(DATA_W-12){sign & field[11]}}, field[11:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ext_unit_arbiter.sv
// rtl/ext_unit_arbiter.sv - round-robin arbiter sharing one extension unit
// Purpose: accepts one request at a time from two requesters, extends the
//          captured field in EXT and presents the registered result in RESP
//          until the consumer takes it.
// Ports:   clk  in  system clock
//          rst  in  synchronous active-high reset
//          bus  slave modport of ext_unit_arbiter_if (requests, response, busy)
module ext_unit_arbiter
  import ext_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ext_unit_arbiter_if.slave  bus
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rr_ptr;
  logic [FIELD_W-1:0]  r_field;
  logic [1:0]          r_width;
  logic                r_sign;
  logic                r_id;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_id;
  logic                r_rsp_valid;

  logic                w_other;
  logic                w_winner;
  logic                w_win_valid;
  logic [NREQ-1:0]     w_req_ready;
  logic                w_accept;
  logic                w_rsp_hs;
  logic [FIELD_W-1:0]  w_win_field;
  logic [1:0]          w_win_width;
  logic [DATA_W-1:0]   w_ext;

  assign w_other = ~r_rr_ptr;

  // Winner selection: the pointer's requester has priority, the other one
  // is taken only when the preferred one is idle.
  always_comb begin
    w_winner    = r_rr_ptr;
    w_win_valid = 1'b0;
    if (bus.req_valid[r_rr_ptr]) begin
      w_winner    = r_rr_ptr;
      w_win_valid = 1'b1;
    end else if (bus.req_valid[w_other]) begin
      w_winner    = w_other;
      w_win_valid = 1'b1;
    end
  end

  assign w_win_field = w_winner ? bus.req_field[2*FIELD_W-1:FIELD_W] : bus.req_field[FIELD_W-1:0];
  assign w_win_width = w_winner ? bus.req_width[3:2] : bus.req_width[1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    case (r_state)
      IDLE: begin
        if (w_win_valid) begin
          w_req_ready[w_winner] = 1'b1;
          w_state_nxt           = EXT;
        end
      end
      EXT:     w_state_nxt = RESP;
      RESP: begin
        if (r_rsp_valid && bus.rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = (r_state == IDLE) && w_win_valid;
  assign w_rsp_hs = (r_state == RESP) && r_rsp_valid && bus.rsp_ready;

  ext_core u_ext_core (
    .field  (r_field),
    .width  (r_width),
    .sign   (r_sign),
    .result (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= 1'b0;
      r_field     <= '0;
      r_width     <= W1;
      r_sign      <= 1'b0;
      r_id        <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_field <= w_win_field;
        r_width <= w_win_width;
        r_sign  <= bus.req_sign[w_winner];
        r_id    <= w_winner;
      end
      if (r_state == EXT) begin
        r_rsp_data  <= w_ext;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end else if (w_rsp_hs) begin
        // Hand priority to the requester that was not just served.
        r_rsp_valid <= 1'b0;
        r_rr_ptr    <= ~r_rsp_id;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ext_unit_arbiter.sv
// tb/tb_ext_unit_arbiter.sv - scoreboard bench for ext_unit_arbiter
module tb_ext_unit_arbiter;
  import ext_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ext_unit_arbiter_if bus();

  ext_unit_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          id;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  logic [15:0] exp_data [2];
  exp_t        e;
  int          cyc = 0;
  int          errs = 0;
  int          chks = 0;
  int          rsp_count = 0;
  logic        hold_pending = 1'b0;
  logic [15:0] hold_data;
  logic        hold_id;
  logic        prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    chks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic fail(input string name);
    chks++;
    errs++;
    $display("FAIL %s: bound expired or event missing", name);
  endtask

  // Monitor: logs acceptances into the scoreboard and checks every response.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_pending) begin
        check("hold_valid", 32'(bus.rsp_valid), 32'd1);
        check("hold_data", 32'(bus.rsp_data), 32'(hold_data));
        check("hold_id", 32'(bus.rsp_id), 32'(hold_id));
      end
      hold_pending = bus.rsp_valid && !bus.rsp_ready;
      hold_data    = bus.rsp_data;
      hold_id      = bus.rsp_id;
      if (bus.busy) check("no_grant_busy", 32'(bus.req_ready), 32'd0);
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb.push_back('{i, exp_data[i], cyc});
          grant_log.push_back(i);
        end
      end
      if (bus.rsp_valid && !prev_valid) begin
        if (sb.size() == 0) fail("rsp_without_request");
        else check("latency", cyc - sb[0].cyc, 32'd2);
      end
      prev_valid = bus.rsp_valid;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chks++;
          errs++;
          $display("FAIL unexpected_rsp: got id=%0d data=%h expected none", bus.rsp_id, bus.rsp_data);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          rsp_count++;
        end
      end
    end else begin
      hold_pending = 1'b0;
      prev_valid   = 1'b0;
    end
  end

  task automatic set_req(input int id, input logic [11:0] f, input logic [1:0] w,
                         input logic s, input logic [15:0] expv);
    exp_data[id]              = expv;
    bus.req_field[id*12 +: 12] = f;
    bus.req_width[id*2 +: 2]   = w;
    bus.req_sign[id]           = s;
    bus.req_valid[id]          = 1'b1;
  endtask

  task automatic wait_accept(input int id, input string name);
    bit got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.req_valid[id] && bus.req_ready[id]) got = 1;
    end
    if (!got) fail(name);
    @(posedge clk);
    #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !bus.busy && !bus.rsp_valid) got = 1;
    end
    if (!got) fail(name);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id, input logic [11:0] f, input logic [1:0] w,
                       input logic s, input logic [15:0] expv, input string name);
    set_req(id, f, w, s, expv);
    wait_accept(id, name);
    wait_done(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errs + 1, chks + 1);
    $fatal(1);
  end

  initial begin
    int exp_g [4] = '{0, 1, 0, 1};
    bit got;

    bus.req_valid = '0;
    bus.req_field = '0;
    bus.req_width = '0;
    bus.req_sign  = '0;
    bus.rsp_ready = 1'b1;
    exp_data[0]   = '0;
    exp_data[1]   = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'h0000);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);

    // Single request, ready in the same cycle.
    set_req(0, 12'h001, W1, 1'b1, 16'hFFFF);
    #1;
    check("t1_ready_same_cycle", 32'(bus.req_ready), 32'b01);
    wait_accept(0, "t1_accept");
    wait_done("t1_done");

    // Extension vectors.
    issue(1, 12'h080, W8,  1'b1, 16'hFF80, "v_w8_s");
    issue(1, 12'h080, W8,  1'b0, 16'h0080, "v_w8_z");
    issue(1, 12'hF07, W4,  1'b1, 16'h0007, "v_w4_upper");
    issue(0, 12'h008, W4,  1'b1, 16'hFFF8, "v_w4_neg");
    issue(1, 12'h0FE, W1,  1'b1, 16'h0000, "v_w1_zero");
    issue(0, 12'h001, W1,  1'b0, 16'h0001, "v_w1_z");
    issue(0, 12'h7FF, W12, 1'b1, 16'h07FF, "v_w12_pos");
    issue(1, 12'h800, W12, 1'b0, 16'h0800, "v_w12_z");
    issue(1, 12'hA55, W8,  1'b0, 16'h0055, "v_w8_upper");

    // Both requesters held valid from reset: grants alternate.
    rst = 1'b1;
    set_req(0, 12'h0F0, W8, 1'b1, 16'hFFF0);
    set_req(1, 12'h00A, W4, 1'b0, 16'h000A);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    grant_log.delete();
    rsp_count = 0;
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      #1;
      if (rsp_count >= 4) got = 1;
    end
    if (!got) fail("alt_responses");
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    check("alt_grant_count", 32'(grant_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < grant_log.size()) check("alt_grant_order", 32'(grant_log[k]), 32'(exp_g[k]));
    end
    wait_done("alt_done");

    // Back-pressure: five stalled cycles, handshake on the sixth.
    bus.rsp_ready = 1'b0;
    set_req(0, 12'h800, W12, 1'b1, 16'hF800);
    wait_accept(0, "bp_accept");
    set_req(1, 12'h00C, W4, 1'b1, 16'hFFFC);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1;
    end
    if (!got) fail("bp_rsp_valid");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_data", 32'(bus.rsp_data), 32'hF800);
      check("bp_id", 32'(bus.rsp_id), 32'd0);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    wait_accept(1, "bp_next_accept");
    wait_done("bp_done");

    // Serve requester 0 so the pointer moves to 1, then reset during EXT.
    issue(0, 12'h3C0, W8, 1'b1, 16'hFFC0, "pre_rst");
    set_req(1, 12'h123, W8, 1'b1, 16'h0023);
    wait_accept(1, "rst_ext_accept");
    check("rst_ext_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("rst_ext_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_ext_data", 32'(bus.rsp_data), 32'h0000);
    check("rst_ext_id", 32'(bus.rsp_id), 32'd0);
    check("rst_ext_busy_low", 32'(bus.busy), 32'd0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    set_req(0, 12'h005, W4, 1'b1, 16'h0005);
    set_req(1, 12'h0FF, W8, 1'b1, 16'hFFFF);
    #1;
    check("rst_ext_ptr0", 32'(bus.req_ready), 32'b01);
    wait_accept(0, "post_rst_acc0");
    wait_accept(1, "post_rst_acc1");
    wait_done("post_rst_done");

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
